rr_grant_sched8: RTL



---
 rtl/rr_grant_sched8_pkg.sv | 12 +
 rtl/rr_pick8.sv | 30 +++
 rtl/rr_grant_sched8.sv | 112 +++++++++++
 3 files changed

// File: rtl/rr_grant_sched8_pkg.sv
// Shared definitions for the 8-way round-robin grant scheduler.
package rr_grant_sched8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin picker: first set request bit at or after ptr, wrapping modulo 8.
module rr_pick8
  import rr_grant_sched8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot_s;
  logic [IDX_W-1:0]   off_s;

  // Rotate so the ptr position lands at bit 0; a zero ptr shifts the upper term out entirely.
  assign rot_s = (req_i >> ptr_i) | (req_i << (NUM_REQ_W - {1'b0, ptr_i}));

  // Lowest set bit of the rotated vector, scanned from the top so the last hit wins.
  always_comb begin
    off_s = {IDX_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? IDX_W'(i) : off_s;
    end
  end

  assign any_o = |rot_s;
  assign idx_o = ptr_i + off_s;

endmodule

// File: rtl/rr_grant_sched8.sv
// Round-robin scheduler sharing one 8-line select bus; grants are held until
// release, request drop, or MAX_HOLD cycles, with one idle cycle between grants.
module rr_grant_sched8
  import rr_grant_sched8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic [NUM_REQ-1:0] grant_sel_o,
  output logic               timeout_o
);

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [NUM_REQ-1:0] SEL_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] sel_q, sel_d;
  logic               timeout_q, timeout_d;

  logic               any_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               owner_exit_s;
  logic               hold_exit_s;

  rr_pick8 u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .any_o (any_s),
    .idx_o (pick_idx_s)
  );

  // Owner-driven exits take priority over the hold limit and suppress timeout.
  assign owner_exit_s = release_i | ~req_i[idx_q];
  assign hold_exit_s  = (hold_q == HOLD_LAST);

  // Next-state, pointer, hold counter and output decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d = ST_GRANT;
          idx_d   = pick_idx_s;
          valid_d = 1'b1;
          hold_d  = {CNT_W{1'b0}};
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (owner_exit_s || hold_exit_s) begin
          state_d   = ST_IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          valid_d   = 1'b0;
          hold_d    = {CNT_W{1'b0}};
          timeout_d = ~owner_exit_s;
        end else begin
          valid_d = 1'b1;
          hold_d  = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        hold_d  = {CNT_W{1'b0}};
      end
    endcase
    sel_d = valid_d ? (SEL_ONE << idx_d) : {NUM_REQ{1'b0}};
  end

  // State and registered outputs; reset clears the bus without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= {IDX_W{1'b0}};
      hold_q    <= {CNT_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      valid_q   <= 1'b0;
      sel_q     <= {NUM_REQ{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid_o = valid_q;
  assign grant_idx_o   = idx_q;
  assign grant_sel_o   = sel_q;
  assign timeout_o     = timeout_q;

endmodule
